encl83e_irq: RTL



---
 rtl/encl83e_irq.sv | 85 ++++++++
 1 files changed

// File: rtl/encl83e_irq.sv
// rtl/encl83e_irq.sv - 8-to-3 latched request encoder with valid/ack handshake
module encl83e_irq #(
    parameter bit EDGE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req_n,
    input  logic       en,
    input  logic       mask_we,
    input  logic [7:0] mask_d,
    input  logic       ack,
    output logic [2:0] code,
    output logic       valid,
    output logic [7:0] pending,
    output logic [7:0] mask
);

    logic [7:0] req_s;
    logic [7:0] req_d;
    logic [7:0] evt;
    logic [7:0] clr;
    logic [7:0] cand;
    logic [2:0] low_idx;

    // Per-source capture event: falling edge of the request, or low level in level mode
    always_comb begin
        if (EDGE) begin
            evt = req_d & ~req_s;
        end else begin
            evt = ~req_s;
        end
    end

    // Clear only the granted source, and only when the consumer acknowledges a live grant
    always_comb begin
        clr = 8'h00;
        if (valid && ack) begin
            clr[code] = 1'b1;
        end
    end

    // Lowest set bit of the unmasked pending set wins; scanning downward lets bit 0 overwrite
    always_comb begin
        cand    = pending & mask;
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (cand[i]) begin
                low_idx = 3'(i);
            end
        end
    end

    // Input synchroniser, pending/mask registers and the grant handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            req_s   <= 8'hFF;
            req_d   <= 8'hFF;
            pending <= 8'h00;
            mask    <= 8'hFF;
            code    <= 3'd0;
            valid   <= 1'b0;
        end else begin
            req_s <= req_n;
            req_d <= req_s;

            // Set has priority over clear so a fresh event on the granted bit is never lost
            pending <= (pending & ~clr) | (en ? evt : 8'h00);

            if (mask_we) begin
                mask <= mask_d;
            end

            if (valid) begin
                // No pre-emption: a grant holds until acked or withdrawn by disable
                if (ack || !en) begin
                    valid <= 1'b0;
                end
            end else if (en && (cand != 8'h00)) begin
                valid <= 1'b1;
                code  <= low_idx;
            end
        end
    end

endmodule
